rv32_instr_encoder: RTL and testbench
=====================================

# rv32_instr_encoder

- Assembles RV32IM instruction fields into 32-bit instruction words. It is the encode direction of the instruction decoder/controller.
- Used by processor test infrastructure to generate instruction streams for instruction memory and to drive the controller with legal words.
- Accepts field descriptors over a valid/ready input, checks them for encodability, and buffers the encoded words in an output FIFO with valid/ready backpressure.
- Maintains emitted-word and error counters.

## Interface

Parameters:
- DEPTH, 2, output FIFO entries. Power of two, at least 2.
- CNT_W, 16, width of the emitted and error counters.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  reset. One clock; reset is asynchronous and active-low.
- IN_VALID  in  1  descriptor present.
- IN_READY  out  1  encoder can accept a descriptor.
- TYPE_SEL  in  3  format code: 0=B, 1=J, 2=S, 3=U, 4=I, 5=R. Values 6 and 7 are illegal.
- OPCODE  in  7  major opcode.
- FUNC3  in  3  funct3 field.
- FUNC7  in  7  funct7 field (R only).
- RD, RS1, RS2  in  5 each  register indices.
- IMM  in  32  signed immediate as a byte offset or value (U uses IMM[31:12]).
- OUT_VALID  out  1  FIFO head valid.
- OUT_READY  in  1  consumer takes the head.
- OUT_INSTR  out  32  encoded word at the FIFO head.
- OUT_ILLEGAL  out  1  head word was substituted because the descriptor was illegal.
- EMIT_COUNT  out  CNT_W  words popped.
- ERR_COUNT  out  CNT_W  illegal descriptors accepted.

## Operation

Encoding (MSB to LSB):
- R: FUNC7, RS2, RS1, FUNC3, RD, OPCODE.
- I: IMM[11:0], RS1, FUNC3, RD, OPCODE.
- S: IMM[11:5], RS2, RS1, FUNC3, IMM[4:0], OPCODE.
- B: IMM[12], IMM[10:5], RS2, RS1, FUNC3, IMM[4:1], IMM[11], OPCODE.
- U: IMM[31:12], RD, OPCODE.
- J: IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD, OPCODE.

Legality checks (a descriptor is illegal if any check fails):
- TYPE_SEL is greater than 5.
- OPCODE[1:0] is not 2'b11.
- I or S: IMM[31:11] is not all-equal (not 12-bit signed).
- B: IMM[31:12] is not all-equal, or IMM[0] is 1.
- J: IMM[31:20] is not all-equal, or IMM[0] is 1.
- U: IMM[11:0] is not zero.

Illegal handling:
- The FIFO entry is written as word 32'h00000013 (NOP) with its illegal flag set to 1.
- ERR_COUNT increments on the same accept edge.

FIFO and handshake:
- Entries hold {illegal, instr[31:0]}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy counter runs 0..DEPTH.
- IN_READY = (occupancy != DEPTH). It depends only on registered state, not on OUT_READY.
- Accept happens when IN_VALID & IN_READY at the edge. Fields are encoded combinationally and written at that edge.
- Pop happens when OUT_VALID & OUT_READY at the edge; EMIT_COUNT increments.
- OUT_VALID = (occupancy != 0). OUT_INSTR and OUT_ILLEGAL are read from the head entry.
- When OUT_VALID is 0, OUT_INSTR and OUT_ILLEGAL read 0.
- A simultaneous accept and pop leaves occupancy unchanged, with both pointers advancing.
- Words leave in accept order.
- Counters wrap modulo 2^CNT_W without saturating.

Reset (RESET_N low), immediate and asynchronous:
- Occupancy and both pointers go to 0.
- OUT_VALID = 0, OUT_INSTR = 0, OUT_ILLEGAL = 0.
- IN_READY = 1 once reset is released; it is also 1 during reset.
- EMIT_COUNT = 0, ERR_COUNT = 0.
- Buffered words are discarded.
- The first accept is allowed on the first rising edge with RESET_N high.

## Timing

- Latency: a descriptor accepted at edge N is visible with OUT_VALID = 1 after edge N. It can be popped at edge N+1, giving 1-cycle latency.
- Throughput: one word per cycle when OUT_READY is held at 1.
- Full FIFO: IN_READY = 0 for the whole cycle, even if OUT_READY = 1. A push is next possible on the edge after a pop.
- Empty FIFO: no pop occurs, EMIT_COUNT holds, and OUT_READY is ignored.
- The consumer must not see OUT_INSTR change while OUT_VALID is 1 and OUT_READY is 0. The head is stable until popped.

## Test plan

- ADDI x1,x0,5 (TYPE 4, OPCODE 0010011, RD 1, IMM 5), OUT_READY = 1: OUT_INSTR = 0x00500093, OUT_ILLEGAL = 0, EMIT_COUNT = 1.
- Back-to-back stream with OUT_READY = 1; expected outputs appear one per cycle in order:
  - SUB x3,x1,x2 (FUNC7 0100000) gives 0x402081B3.
  - BEQ x1,x2,+8 gives 0x00208463.
  - JAL x1,-4 gives 0xFFDFF0EF.
  - LUI x5,0x12345000 gives 0x123452B7.
- Illegal descriptors:
  - B with IMM = 3 gives 0x00000013 with OUT_ILLEGAL = 1.
  - I with IMM = 0x800 gives the same, and ERR_COUNT = 2.
  - TYPE_SEL = 7 gives the same, and ERR_COUNT = 3.
- Backpressure with OUT_READY = 0 and three descriptors offered:
  - IN_READY drops after the 2nd accept, and the 3rd descriptor is held.
  - Head word stays stable.
  - After OUT_READY rises, all three words emerge in order and occupancy returns to 0.
- Wrap-around: 10 accept/pop pairs with simultaneous push and pop at occupancy 1. Occupancy stays 1 and data is correct across the pointer wrap.
- Reset mid-stream: with 2 words buffered, pulse RESET_N low between edges. OUT_VALID = 0 immediately, counters are 0, and the next accepted descriptor is the first word out.

Source files
------------

// File: rtl/rv32_instr_encoder.sv
// RV32IM instruction encoder: legality-checks field descriptors, packs them into
// 32-bit words and queues them in a small FIFO with valid/ready on both sides.
module rv32_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       TYPE_SEL,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNC3,
  input  logic [6:0]       FUNC7,
  input  logic [4:0]       RD,
  input  logic [4:0]       RS1,
  input  logic [4:0]       RS2,
  input  logic [31:0]      IMM,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_INSTR,
  output logic             OUT_ILLEGAL,
  output logic [CNT_W-1:0] EMIT_COUNT,
  output logic [CNT_W-1:0] ERR_COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

  localparam logic [2:0] FMT_B = 3'd0;
  localparam logic [2:0] FMT_J = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_I = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // True when v survives an arithmetic shift by msb as pure sign extension,
  // i.e. v[31:msb] are all equal.
  function automatic logic fits_signed(input logic signed [31:0] v, input int msb);
    logic signed [31:0] s;
    s = v >>> msb;
    return (s == 32'sd0) || (s == -32'sd1);
  endfunction

  function automatic logic desc_legal(input logic [2:0] fmt, input logic [6:0] op,
                                      input logic signed [31:0] imm);
    logic ok;
    ok = (op[1:0] == 2'b11);
    case (fmt)
      FMT_I, FMT_S: ok = ok && fits_signed(imm, 11);
      FMT_B:        ok = ok && fits_signed(imm, 12) && !imm[0];
      FMT_J:        ok = ok && fits_signed(imm, 20) && !imm[0];
      FMT_U:        ok = ok && (imm[11:0] == 12'd0);
      FMT_R:        ok = ok;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] fmt, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2,
                                         input logic signed [31:0] imm);
    logic [31:0] w;
    case (fmt)
      FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
      FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   w = {imm[31:12], rd, op};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

  // Stage p0: combinational check and pack of the offered descriptor
  logic signed [31:0] imm_p0;
  logic               enc_illegal_p0;
  logic [31:0]        enc_word_p0;

  assign imm_p0 = signed'(IMM);

  always_comb begin
    enc_illegal_p0 = !desc_legal(TYPE_SEL, OPCODE, imm_p0);
    enc_word_p0    = NOP_WORD;
    if (!enc_illegal_p0)
      enc_word_p0 = encode(TYPE_SEL, OPCODE, FUNC3, FUNC7, RD, RS1, RS2, imm_p0);
  end

  // Stage p1: output FIFO holding {illegal, instr}
  logic [32:0]      fifo_mem_p1 [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [PTR_W:0]   occ_p1;
  logic [32:0]      head_p1;
  logic             push;
  logic             pop;

  assign IN_READY  = (occ_p1 != OCC_FULL);
  assign OUT_VALID = (occ_p1 != '0);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_p1  <= '0;
      rd_ptr_p1  <= '0;
      occ_p1     <= '0;
      EMIT_COUNT <= '0;
      ERR_COUNT  <= '0;
    end else begin
      if (push) begin
        wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
        if (enc_illegal_p0)
          ERR_COUNT <= ERR_COUNT + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_p1  <= rd_ptr_p1 + PTR_W'(1);
        EMIT_COUNT <= EMIT_COUNT + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_p1 <= occ_p1 + (PTR_W+1)'(1);
        2'b01:   occ_p1 <= occ_p1 - (PTR_W+1)'(1);
        default: occ_p1 <= occ_p1;
      endcase
    end
  end

  // Storage is not reset; the pointers alone decide what is live.
  always_ff @(posedge CLK) begin
    if (push)
      fifo_mem_p1[wr_ptr_p1] <= {enc_illegal_p0, enc_word_p0};
  end

  assign head_p1     = fifo_mem_p1[rd_ptr_p1];
  assign OUT_INSTR   = OUT_VALID ? head_p1[31:0] : 32'd0;
  assign OUT_ILLEGAL = OUT_VALID ? head_p1[32]   : 1'b0;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench for rv32_instr_encoder: known RV32 words queued at drive time
// and compared at each pop, plus handshake, counter and reset checks.
module tb_rv32_instr_encoder;

  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             IN_VALID;
  logic             IN_READY;
  logic [2:0]       TYPE_SEL;
  logic [6:0]       OPCODE;
  logic [2:0]       FUNC3;
  logic [6:0]       FUNC7;
  logic [4:0]       RD, RS1, RS2;
  logic [31:0]      IMM;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [31:0]      OUT_INSTR;
  logic             OUT_ILLEGAL;
  logic [CNT_W-1:0] EMIT_COUNT;
  logic [CNT_W-1:0] ERR_COUNT;

  rv32_instr_encoder #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .TYPE_SEL(TYPE_SEL), .OPCODE(OPCODE), .FUNC3(FUNC3), .FUNC7(FUNC7),
    .RD(RD), .RS1(RS1), .RS2(RS2), .IMM(IMM),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR),
    .OUT_ILLEGAL(OUT_ILLEGAL), .EMIT_COUNT(EMIT_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [32:0] exp_q [$];

  always @(posedge CLK) cyc++;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop side of the scoreboard: the head seen at a negedge with ready high leaves next edge.
  always @(negedge CLK) begin
    if (RESET_N && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_word", {31'd0, OUT_ILLEGAL, OUT_INSTR}, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check_val("instr", 64'(OUT_INSTR), 64'(e[31:0]));
        check_val("illegal", 64'(OUT_ILLEGAL), 64'(e[32]));
      end
    end
  end

  task automatic set_desc(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_w, input logic exp_ill);
    TYPE_SEL = t; OPCODE = op; FUNC3 = f3; FUNC7 = f7;
    RD = rd; RS1 = rs1; RS2 = rs2; IMM = imm;
    IN_VALID = 1'b1;
    exp_q.push_back({exp_ill, exp_w});
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) check_val("accept_timeout", 64'd0, 64'd1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] exp_w, input logic exp_ill);
    set_desc(t, op, f3, f7, rd, rs1, rs2, imm, exp_w, exp_ill);
    wait_accept();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    check_val("watchdog", 64'd0, 64'd1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    logic [31:0] head0;
    RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    TYPE_SEL = '0; OPCODE = '0; FUNC3 = '0; FUNC7 = '0;
    RD = '0; RS1 = '0; RS2 = '0; IMM = '0;
    #2;
    check_val("rst_in_ready", 64'(IN_READY), 64'd1);
    check_val("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check_val("rst_out_instr", 64'(OUT_INSTR), 64'd0);
    check_val("rst_out_illegal", 64'(OUT_ILLEGAL), 64'd0);
    check_val("rst_emit", 64'(EMIT_COUNT), 64'd0);
    check_val("rst_err", 64'(ERR_COUNT), 64'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RESET_N = 1'b1;
    OUT_READY = 1'b1;

    // ADDI x1,x0,5 and its one-cycle latency
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    check_val("latency_valid", 64'(OUT_VALID), 64'd1);
    wait_cycles(2);
    check_val("emit_after_addi", 64'(EMIT_COUNT), 64'd1);

    // Back-to-back stream
    c0 = cyc;
    send(3'd5, 7'b0110011, 3'd0, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
    send(3'd0, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b0);
    send(3'd1, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1'b0);
    send(3'd3, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    check_val("throughput_cycles", 64'(cyc - c0), 64'd5);
    wait_cycles(3);
    check_val("emit_after_stream", 64'(EMIT_COUNT), 64'd6);

    // Illegal descriptors
    send(3'd0, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0000_0013, 1'b1);
    check_val("err_b_odd", 64'(ERR_COUNT), 64'd1);
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 32'h0000_0013, 1'b1);
    check_val("err_i_range", 64'(ERR_COUNT), 64'd2);
    send(3'd7, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0000_0013, 1'b1);
    check_val("err_type7", 64'(ERR_COUNT), 64'd3);
    send(3'd4, 7'b0010010, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0000_0013, 1'b1);
    check_val("err_opcode", 64'(ERR_COUNT), 64'd4);
    send(3'd3, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
    check_val("err_u_low", 64'(ERR_COUNT), 64'd5);
    // Largest legal negative I immediate stays legal
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    check_val("err_i_edge", 64'(ERR_COUNT), 64'd5);
    wait_cycles(3);
    check_val("emit_after_illegal", 64'(EMIT_COUNT), 64'd12);

    // Backpressure: third descriptor held while the FIFO is full
    OUT_READY = 1'b0;
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0070_0113, 1'b0);
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd9, 32'h0090_0193, 1'b0);
    check_val("full_in_ready", 64'(IN_READY), 64'd0);
    set_desc(3'd5, 7'b0110011, 3'd0, 7'd0, 5'd4, 5'd2, 5'd3, 32'd0, 32'h0031_0233, 1'b0);
    @(negedge CLK);
    head0 = OUT_INSTR;
    check_val("bp_head", 64'(head0), 64'h0070_0113);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_val("bp_in_ready", 64'(IN_READY), 64'd0);
      check_val("bp_head_stable", 64'(OUT_INSTR), 64'(head0));
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_accept();
    wait_cycles(4);
    check_val("bp_drained", 64'(OUT_VALID), 64'd0);
    check_val("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Wrap-around with simultaneous push/pop at occupancy 1
    OUT_READY = 1'b0;
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0000_0093, 1'b0);
    OUT_READY = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      logic [11:0] im;
      im = 12'(i);
      send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i),
           {im, 5'd0, 3'd0, 5'd1, 7'b0010011}, 1'b0);
      check_val("wrap_occ1", {62'd0, OUT_VALID, IN_READY}, 64'd3);
    end
    wait_cycles(3);
    check_val("emit_after_wrap", 64'(EMIT_COUNT), 64'd26);

    // Reset mid-stream with two words buffered
    OUT_READY = 1'b0;
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd1, 32'h0010_0313, 1'b0);
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd2, 32'h0020_0393, 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    check_val("mid_rst_instr", 64'(OUT_INSTR), 64'd0);
    check_val("mid_rst_emit", 64'(EMIT_COUNT), 64'd0);
    check_val("mid_rst_err", 64'(ERR_COUNT), 64'd0);
    check_val("mid_rst_ready", 64'(IN_READY), 64'd1);
    RESET_N = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    send(3'd4, 7'b0010011, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'd3, 32'h0030_0413, 1'b0);
    wait_cycles(3);
    check_val("post_rst_emit", 64'(EMIT_COUNT), 64'd1);
    check_val("post_rst_valid", 64'(OUT_VALID), 64'd0);
    check_val("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
